// File: rtl/float_to_int_pipe_pkg.sv
// Shared float32 definitions for the FPU conversion blocks: field layout, bias,
// rounding-mode encodings, operand class codes and the rounding-increment decision.
package float_to_int_pipe_pkg;

    localparam int         F32_EXP_W   = 8;
    localparam int         F32_FRAC_W  = 23;
    localparam int         F32_BIAS    = 127;
    localparam logic [7:0] F32_EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fclass_e;

    // Whether the truncated magnitude must be bumped by one; encodings 101-111 truncate.
    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic guard, input logic sticky);
        logic up;
        case (rm_e'(rm))
            RM_RNE:  up = guard & (sticky | lsb);
            RM_RDN:  up = sign & (guard | sticky);
            RM_RUP:  up = ~sign & (guard | sticky);
            RM_RMM:  up = guard;
            default: up = 1'b0;
        endcase
        return up;
    endfunction

endpackage

// File: rtl/float_classify.sv
// Combinational float32 field split and class code (zero/subnormal/normal/inf/qNaN/sNaN).
module float_classify
    import float_to_int_pipe_pkg::*;
(
    input  logic [31:0]           op,
    output logic                  sign,
    output logic [F32_EXP_W-1:0]  exp,
    output logic [F32_FRAC_W-1:0] fract,
    output fclass_e               cls
);

    assign sign  = op[31];
    assign exp   = op[30:23];
    assign fract = op[22:0];

    always_comb begin
        if (op[30:23] == '0)
            cls = (op[22:0] == '0) ? CLS_ZERO : CLS_SUB;
        else if (op[30:23] == F32_EXP_MAX) begin
            if (op[22:0] == '0)
                cls = CLS_INF;
            else
                cls = op[22] ? CLS_QNAN : CLS_SNAN;
        end else
            cls = CLS_NORM;
    end

endmodule

// File: rtl/float_to_int_pipe.sv
// Two-stage handshaked float32 -> INT_WIDTH integer converter (fcvt.w.s / fcvt.wu.s).
// Define FLOAT_TO_INT_ROUND_EN to honour in_rm; otherwise every conversion truncates (RTZ).
module float_to_int_pipe
    import float_to_int_pipe_pkg::*;
#(
    parameter int INT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_op,
    input  logic                 in_unsigned,
    input  logic [2:0]           in_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_WIDTH-1:0] out_res,
    output logic                 out_nv,
    output logic                 out_nx
);

    // Magnitude keeps one bit above the result so 2^W can still be range-checked after rounding.
    localparam int         MAG_W    = INT_WIDTH + 1;
    localparam int         FIX_W    = MAG_W + 24;
    localparam logic [7:0] EXP_HALF = 8'(F32_BIAS - 1);
    localparam logic [7:0] EXP_OVF  = 8'(F32_BIAS + INT_WIDTH + 1);

    localparam logic [MAG_W:0] LIM_SPOS = (MAG_W+1)'((64'd1 << (INT_WIDTH - 1)) - 64'd1);
    localparam logic [MAG_W:0] LIM_SNEG = (MAG_W+1)'(64'd1 << (INT_WIDTH - 1));
    localparam logic [MAG_W:0] LIM_U    = (MAG_W+1)'((64'd1 << INT_WIDTH) - 64'd1);
    localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             inf;
        logic             ovf;
        logic             uns;
`ifdef FLOAT_TO_INT_ROUND_EN
        logic [2:0]       rm;
`endif
        logic [MAG_W-1:0] mag;
        logic             guard;
        logic             sticky;
    } s1_t;

    logic                 s1_valid;
    s1_t                  s1;
    s1_t                  s1_next;
    logic                 s1_advance;
    logic                 c_sign;
    logic [7:0]           c_exp;
    logic [22:0]          c_fract;
    fclass_e              c_cls;
    logic [FIX_W-1:0]     aligned;
    logic                 inc;
    logic [MAG_W:0]       rounded;
    logic [INT_WIDTH-1:0] res;
    logic                 nv;
    logic                 nx;

    float_classify u_classify (
        .op    (in_op),
        .sign  (c_sign),
        .exp   (c_exp),
        .fract (c_fract),
        .cls   (c_cls)
    );

    // Stage 1: the significand lands with its binary point 24 bits up, so the low 24 bits
    // hold guard and sticky; exponents below 0.5 or beyond the range never use the shifter.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        s1_next      = '0;
        s1_next.sign = c_sign;
        s1_next.uns  = in_unsigned;
`ifdef FLOAT_TO_INT_ROUND_EN
        s1_next.rm   = in_rm;
`endif
        aligned = FIX_W'({1'b1, c_fract}) << (c_exp - EXP_HALF);
        case (c_cls)
            CLS_ZERO: ;
            CLS_SUB:  s1_next.sticky = 1'b1;
            CLS_NORM: begin
                if (c_exp >= EXP_OVF)
                    s1_next.ovf = 1'b1;
                else if (c_exp < EXP_HALF)
                    s1_next.sticky = 1'b1;
                else begin
                    s1_next.mag    = aligned[FIX_W-1:24];
                    s1_next.guard  = aligned[23];
                    s1_next.sticky = |aligned[22:0];
                end
            end
            CLS_INF:  s1_next.inf = 1'b1;
            default:  s1_next.nan = 1'b1;
        endcase
    end

`ifdef FLOAT_TO_INT_ROUND_EN
    assign inc = round_up(s1.rm, s1.sign, s1.mag[0], s1.guard, s1.sticky);
`else
    logic unused_rm;
    assign unused_rm = ^in_rm;
    assign inc       = 1'b0;
`endif

    assign rounded = {1'b0, s1.mag} + {{MAG_W{1'b0}}, inc};

    // Stage 2: range check on the rounded magnitude, saturate, then apply the sign.
    always_comb begin
        nv  = 1'b0;
        res = s1.sign ? -rounded[INT_WIDTH-1:0] : rounded[INT_WIDTH-1:0];
        if (s1.nan) begin
            nv  = 1'b1;
            res = s1.uns ? '1 : INT_MAX;
        end else if (s1.inf || s1.ovf) begin
            nv  = 1'b1;
            res = s1.uns ? (s1.sign ? '0 : '1) : (s1.sign ? INT_MIN : INT_MAX);
        end else if (s1.uns) begin
            if (s1.sign && rounded != '0) begin
                nv  = 1'b1;
                res = '0;
            end else if (!s1.sign && rounded > LIM_U) begin
                nv  = 1'b1;
                res = '1;
            end
        end else if (s1.sign ? (rounded > LIM_SNEG) : (rounded > LIM_SPOS)) begin
            nv  = 1'b1;
            res = s1.sign ? INT_MIN : INT_MAX;
        end
        nx = (s1.guard | s1.sticky) & ~nv;
    end

    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;

    // NOTE: pipeline state uses non-blocking assignments so each stage sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_nv    <= 1'b0;
            out_nx    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid)
                    s1 <= s1_next;
            end
            if (!out_valid || out_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_res <= res;
                    out_nv  <= nv;
                    out_nx  <= nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_float_to_int_pipe.sv
// Scoreboard bench for float_to_int_pipe: 32-bit and 16-bit instances, directed vectors.
module tb_float_to_int_pipe;

`ifdef FLOAT_TO_INT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic        nx;
        bit          lat;
        int          acc;
        string       name;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_valid16;
    logic [31:0] in_op;
    logic        in_unsigned;
    logic [2:0]  in_rm;
    logic        out_ready;
    logic        out_ready16;
    logic        in_ready;
    logic        in_ready16;
    logic        out_valid;
    logic        out_valid16;
    logic [31:0] out_res;
    logic [15:0] out_res16;
    logic        out_nv;
    logic        out_nx;
    logic        out_nv16;
    logic        out_nx16;

    exp_t q32[$];
    exp_t q16[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    float_to_int_pipe #(.INT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_unsigned(in_unsigned), .in_rm(in_rm), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_nv(out_nv), .out_nx(out_nx)
    );

    float_to_int_pipe #(.INT_WIDTH(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_op(in_op), .in_unsigned(in_unsigned), .in_rm(in_rm), .out_valid(out_valid16),
        .out_ready(out_ready16), .out_res(out_res16), .out_nv(out_nv16), .out_nx(out_nx16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Drive one operand from posedge+1 until accepted; the expectation is queued at acceptance.
    task automatic send(input string name, input bit w16, input logic [31:0] op, input bit uns,
                        input logic [2:0] rm, input logic [31:0] res, input bit nv, input bit nx,
                        input bit lat);
        exp_t e;
        bit   done = 1'b0;
        e.res = res; e.nv = nv; e.nx = nx; e.lat = lat; e.acc = 0; e.name = name;
        in_op = op; in_unsigned = uns; in_rm = rm;
        if (w16) in_valid16 = 1'b1; else in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            if (w16 ? in_ready16 : in_ready) begin
                e.acc = cycle;
                if (w16) q16.push_back(e); else q32.push_back(e);
                done = 1'b1;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_valid16 = 1'b0;
        if (!done) fail_now({name, " accept timeout"});
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && (q32.size() != 0 || q16.size() != 0); t++)
            @(posedge clock);
        @(posedge clock); #1;
        if (q32.size() != 0 || q16.size() != 0) fail_now("drain timeout, results missing");
    endtask

    logic [31:0] held_res;
    logic        held_nv;
    logic        held_nx;
    bit          held_valid = 1'b0;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (held_valid && out_valid) begin
            check("stalled out_res stable", out_res, held_res);
            check("stalled out_nv stable", {31'b0, out_nv}, {31'b0, held_nv});
            check("stalled out_nx stable", {31'b0, out_nx}, {31'b0, held_nx});
        end
        held_valid = out_valid && !out_ready;
        held_res   = out_res;
        held_nv    = out_nv;
        held_nx    = out_nx;
        if (out_valid && out_ready) begin
            if (q32.size() == 0) fail_now("unexpected output on 32-bit instance");
            else begin
                e = q32.pop_front();
                check({e.name, " res"}, out_res, e.res);
                check({e.name, " nv"}, {31'b0, out_nv}, {31'b0, e.nv});
                check({e.name, " nx"}, {31'b0, out_nx}, {31'b0, e.nx});
                if (e.lat) check({e.name, " latency"}, cycle - e.acc, 32'd2);
            end
        end
        if (out_valid16 && out_ready16) begin
            if (q16.size() == 0) fail_now("unexpected output on 16-bit instance");
            else begin
                e = q16.pop_front();
                check({e.name, " res"}, {16'h0, out_res16}, e.res);
                check({e.name, " nv"}, {31'b0, out_nv16}, {31'b0, e.nv});
                check({e.name, " nx"}, {31'b0, out_nx16}, {31'b0, e.nx});
                if (e.lat) check({e.name, " latency"}, cycle - e.acc, 32'd2);
            end
        end
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0; in_op = '0;
        in_unsigned = 1'b0; in_rm = 3'b001; out_ready = 1'b1; out_ready16 = 1'b1;
        repeat (2) @(posedge clock); #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_res", out_res, 32'd0);
        check("reset flags", {30'b0, out_nv, out_nx}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // name, w16, op, unsigned, rm, expected result, nv, nx, latency check
        send("pi_rtz",      0, 32'h40490FDB, 0, 3'b001, 32'd3, 0, 1, 1);
        send("1p5_rne",     0, 32'h3FC00000, 0, 3'b000, RND ? 32'd2 : 32'd1, 0, 1, 1);
        send("2p5_rne",     0, 32'h40200000, 0, 3'b000, 32'd2, 0, 1, 1);
        send("2p5_rmm",     0, 32'h40200000, 0, 3'b100, RND ? 32'd3 : 32'd2, 0, 1, 1);
        send("m2p5_rdn",    0, 32'hC0200000, 0, 3'b010, RND ? 32'hFFFFFFFD : 32'hFFFFFFFE, 0, 1, 1);
        send("m2p31_s",     0, 32'hCF000000, 0, 3'b001, 32'h80000000, 0, 0, 1);
        send("p2p31_s",     0, 32'h4F000000, 0, 3'b001, 32'h7FFFFFFF, 1, 0, 1);
        send("below_min_s", 0, 32'hCF000001, 0, 3'b001, 32'h80000000, 1, 0, 1);
        send("qnan_s",      0, 32'h7FC00000, 0, 3'b000, 32'h7FFFFFFF, 1, 0, 1);
        send("qnan_u",      0, 32'h7FC00000, 1, 3'b000, 32'hFFFFFFFF, 1, 0, 1);
        send("snan_u",      0, 32'h7F800001, 1, 3'b001, 32'hFFFFFFFF, 1, 0, 1);
        send("m1_u",        0, 32'hBF800000, 1, 3'b001, 32'd0, 1, 0, 1);
        send("m0p3_u_rtz",  0, 32'hBE99999A, 1, 3'b001, 32'd0, 0, 1, 1);
        send("mzero_s",     0, 32'h80000000, 0, 3'b000, 32'd0, 0, 0, 1);
        send("sub_u_rup",   0, 32'h00000001, 1, 3'b011, RND ? 32'd1 : 32'd0, 0, 1, 1);
        send("minf_s",      0, 32'hFF800000, 0, 3'b001, 32'h80000000, 1, 0, 1);
        send("p2p32_u",     0, 32'h4F800000, 1, 3'b001, 32'hFFFFFFFF, 1, 0, 1);
        send("max_u_exact", 0, 32'h4F7FFFFF, 1, 3'b001, 32'hFFFFFF00, 0, 0, 1);
        send("1p5_rm101",   0, 32'h3FC00000, 0, 3'b101, 32'd1, 0, 1, 1);
        send("0p5_rne",     0, 32'h3F000000, 0, 3'b000, 32'd0, 0, 1, 1);
        send("m0p5_u_rdn",  0, 32'hBF000000, 1, 3'b010, 32'd0, RND, !RND, 1);
        drain();

        // Four back-to-back operands against a 3-cycle downstream stall.
        out_ready = 1'b0;
        fork
            begin
                send("stall_a", 0, 32'h41200000, 0, 3'b001, 32'd10, 0, 0, 0);
                send("stall_b", 0, 32'hC1200000, 0, 3'b001, 32'hFFFFFFF6, 0, 0, 0);
                send("stall_c", 0, 32'h3F800000, 1, 3'b001, 32'd1, 0, 0, 0);
                send("stall_d", 0, 32'h42F60000, 0, 3'b001, 32'd123, 0, 0, 0);
            end
            begin
                repeat (3) @(negedge clock);
                check("in_ready low after two accepts", {31'b0, in_ready}, 32'd0);
                check("out_valid during stall", {31'b0, out_valid}, 32'd1);
                repeat (3) begin @(posedge clock); #1; end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages occupied: results are discarded at once.
        out_ready = 1'b0;
        send("rst_a", 0, 32'h41200000, 0, 3'b001, 32'd10, 0, 0, 0);
        send("rst_b", 0, 32'h40490FDB, 0, 3'b001, 32'd3, 0, 1, 0);
        check("stages full before reset", {31'b0, in_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("out_valid cleared by async reset", {31'b0, out_valid}, 32'd0);
        check("out_res cleared by async reset", out_res, 32'd0);
        check("in_ready after async reset", {31'b0, in_ready}, 32'd1);
        q32.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clock); #1;
        check("no stale output after release", {31'b0, out_valid}, 32'd0);

        send("w16_32768_s", 1, 32'h47000000, 0, 3'b001, 32'h00007FFF, 1, 0, 1);
        send("w16_32768_u", 1, 32'h47000000, 1, 3'b001, 32'h00008000, 0, 0, 1);
        send("w16_m32768_s", 1, 32'hC7000000, 0, 3'b001, 32'h00008000, 0, 0, 1);
        send("w16_65536_u", 1, 32'h47800000, 1, 3'b001, 32'h0000FFFF, 1, 0, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
